// File: rtl/ballot_counter_n.sv
// ballot_counter_n: booth FSM, per-button press qualifiers, saturating tallies,
// winner/tie, spoiled count, indexed readout. Macro BALLOT_LOCKOUT_EN enables arm gating.
module ballot_counter_n #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W = 8,
    parameter int HOLD_CYC = 10,
    parameter int ACK_CYC = 100,
    localparam int SEL_W = $clog2(NUM_CAND)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                arm,
    input  logic [NUM_CAND-1:0] button,
    input  logic [SEL_W-1:0]    sel,
    output logic [CNT_W-1:0]    led,
    output logic                armed,
    output logic                vote_ack,
    output logic [SEL_W-1:0]    winner,
    output logic                tie,
    output logic [CNT_W-1:0]    spoiled
);
    localparam int QW = $clog2(HOLD_CYC + 1);
    localparam int AW = $clog2(ACK_CYC + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, ACK, RESULT} state_t;

    state_t state, state_nx;
    logic [QW-1:0] qcnt [NUM_CAND];
    logic [NUM_CAND-1:0] q;
    logic [CNT_W-1:0] tally [NUM_CAND];
    logic [AW-1:0] ack_cnt;
    logic q_any, q_multi;
    logic take_vote, take_spoil;
    logic armed_nx;
    logic [CNT_W-1:0] led_nx, sel_tally, best;
    logic [SEL_W-1:0] best_idx;
    logic dup;

`ifndef BALLOT_LOCKOUT_EN
    logic unused_arm;
    assign unused_arm = arm;
`endif

    assign q_any = |q;
    assign q_multi = |(q & (q - NUM_CAND'(1)));

    // Press qualifiers: one pulse per hold of at least HOLD_CYC samples
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) qcnt[i] <= '0;
            q <= '0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (!button[i]) begin
                    qcnt[i] <= '0;
                    q[i] <= 1'b0;
                end else begin
                    q[i] <= (qcnt[i] == QW'(HOLD_CYC - 1));
                    if (qcnt[i] != QW'(HOLD_CYC))
                        qcnt[i] <= qcnt[i] + QW'(1);
                end
            end
        end
    end

    // Booth next-state and commit decisions
    always_comb begin
        state_nx = state;
        take_vote = 1'b0;
        take_spoil = 1'b0;
        unique case (state)
            IDLE: begin
                if (mode) state_nx = RESULT;
`ifdef BALLOT_LOCKOUT_EN
                else if (arm) state_nx = ARMED;
`else
                else state_nx = ARMED;
`endif
            end
            ARMED: begin
                take_vote = q_any && !q_multi;
                take_spoil = q_multi;
                if (mode) state_nx = RESULT;
                else if (q_any) state_nx = ACK;
            end
            ACK: begin
                if (mode) state_nx = RESULT;
                else if (ack_cnt == AW'(ACK_CYC - 1)) state_nx = IDLE;
            end
            RESULT: begin
                if (!mode) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output pattern selection for the next cycle
    always_comb begin
        sel_tally = '0;
        for (int i = 0; i < NUM_CAND; i++)
            if (sel == SEL_W'(i)) sel_tally = tally[i];
        led_nx = '0;
        if (state_nx == ACK) led_nx = '1;
        else if (state_nx == RESULT) led_nx = sel_tally;
`ifdef BALLOT_LOCKOUT_EN
        armed_nx = (state_nx == ARMED);
`else
        armed_nx = (state_nx == ARMED) || (state_nx == IDLE);
`endif
    end

    // Highest tally, lowest index wins; duplicate maximum flags a tie
    always_comb begin
        best = tally[0];
        best_idx = '0;
        dup = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally[i] > best) begin
                best = tally[i];
                best_idx = SEL_W'(i);
                dup = 1'b0;
            end else if (tally[i] == best) begin
                dup = 1'b1;
            end
        end
    end

    // Saturating tallies for accepted single-button ballots
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
        end else if (take_vote) begin
            for (int i = 0; i < NUM_CAND; i++)
                if (q[i] && tally[i] != CMAX)
                    tally[i] <= tally[i] + CNT_W'(1);
        end
    end

    // State register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ack_cnt <= '0;
            led <= '0;
            armed <= 1'b0;
            vote_ack <= 1'b0;
            spoiled <= '0;
            winner <= '0;
            tie <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ACK && state_nx == ACK)
                ack_cnt <= ack_cnt + AW'(1);
            else
                ack_cnt <= '0;
            led <= led_nx;
            armed <= armed_nx;
            vote_ack <= take_vote;
            if (take_spoil && spoiled != CMAX)
                spoiled <= spoiled + CNT_W'(1);
            winner <= best_idx;
            tie <= dup && (best != '0);
        end
    end
endmodule

// File: tb/tb_ballot_counter_n.sv
// tb_ballot_counter_n: random and directed stimulus against a
// behavioural booth model, plus literal checks of the test plan.
module tb_ballot_counter_n;
    localparam int NUM_CAND = 4;
    localparam int CNT_W = 8;
    localparam int HOLD_CYC = 10;
    localparam int ACK_CYC = 100;
    localparam int SEL_W = $clog2(NUM_CAND);
    localparam int MAXC = (1 << CNT_W) - 1;
`ifdef BALLOT_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif
    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_ACK = 2, PH_RES = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mode = 1'b0;
    logic arm = 1'b0;
    logic [NUM_CAND-1:0] button = '0;
    logic [SEL_W-1:0] sel = '0;
    logic [CNT_W-1:0] led;
    logic armed, vote_ack, tie;
    logic [SEL_W-1:0] winner;
    logic [CNT_W-1:0] spoiled;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    ballot_counter_n #(
        .NUM_CAND(NUM_CAND), .CNT_W(CNT_W),
        .HOLD_CYC(HOLD_CYC), .ACK_CYC(ACK_CYC)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode), .arm(arm),
        .button(button), .sel(sel), .led(led), .armed(armed),
        .vote_ack(vote_ack), .winner(winner), .tie(tie),
        .spoiled(spoiled)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    int hl [NUM_CAND];
    bit pend [NUM_CAND];
    bit newp [NUM_CAND];
    int t [NUM_CAND];
    int sp, phase, ack_left;
    int np, k, best, nbest, bi, rd;
    int m_led, m_win;
    bit m_armed, m_ack, m_tie;

    always @(posedge clock) begin
        started = 1'b1;
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                hl[i] = 0; pend[i] = 0; t[i] = 0;
            end
            sp = 0; phase = PH_IDLE; ack_left = 0;
            m_led = 0; m_win = 0; m_armed = 0; m_ack = 0; m_tie = 0;
        end else begin
            np = 0; k = 0;
            for (int i = 0; i < NUM_CAND; i++)
                if (pend[i]) begin np++; k = i; end
            for (int i = 0; i < NUM_CAND; i++) begin
                newp[i] = button[i] && (hl[i] == HOLD_CYC - 1);
                if (!button[i]) hl[i] = 0;
                else if (hl[i] < HOLD_CYC) hl[i]++;
            end
            best = 0; bi = 0; nbest = 0;
            for (int i = 0; i < NUM_CAND; i++)
                if (t[i] > best) begin best = t[i]; bi = i; end
            for (int i = 0; i < NUM_CAND; i++)
                if (t[i] == best) nbest++;
            m_win = bi;
            m_tie = (best > 0) && (nbest >= 2);
            rd = (int'(sel) < NUM_CAND) ? t[sel] : 0;
            m_ack = 0;
            case (phase)
                PH_IDLE: begin
                    if (mode) phase = PH_RES;
                    else if (!LOCKOUT || arm) phase = PH_ARMED;
                end
                PH_ARMED: begin
                    if (np == 1) begin
                        if (t[k] < MAXC) t[k]++;
                        m_ack = 1;
                    end else if (np >= 2 && sp < MAXC) begin
                        sp++;
                    end
                    if (mode) phase = PH_RES;
                    else if (np > 0) begin
                        phase = PH_ACK;
                        ack_left = ACK_CYC;
                    end
                end
                PH_ACK: begin
                    ack_left--;
                    if (mode) phase = PH_RES;
                    else if (ack_left == 0) phase = PH_IDLE;
                end
                default: begin
                    if (!mode) phase = PH_IDLE;
                end
            endcase
            for (int i = 0; i < NUM_CAND; i++) pend[i] = newp[i];
            if (phase == PH_ACK) m_led = MAXC;
            else if (phase == PH_RES) m_led = rd;
            else m_led = 0;
            m_armed = (phase == PH_ARMED) || (!LOCKOUT && phase == PH_IDLE);
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clock) begin
        if (started) begin
            vectors++;
            if (int'(led) != m_led || armed !== m_armed ||
                vote_ack !== m_ack || int'(winner) != m_win ||
                tie !== m_tie || int'(spoiled) != sp) begin
                miscompares++;
                $display("FAIL model t=%0t led=%0d/%0d armed=%0b/%0b ack=%0b/%0b win=%0d/%0d tie=%0b/%0b spoiled=%0d/%0d",
                         $time, led, m_led, armed, m_armed, vote_ack, m_ack,
                         winner, m_win, tie, m_tie, spoiled, sp);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; button = '0; arm = 1'b0; mode = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic arm_booth();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic fast_vote(input int idx);
        arm_booth();
        button = NUM_CAND'(1) << idx;
        repeat (HOLD_CYC) step();
        mode = 1'b1;
        step();
        button = '0;
        mode = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst_led", int'(led), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_spoiled", int'(spoiled), 0);
        check("rst_winner", int'(winner), 0);

        do_reset();
        arm_booth();
        check("armed_after_arm", int'(armed), 1);
        button = 4'b0100;
        repeat (HOLD_CYC) step();
        check("no_early_ack", int'(vote_ack), 0);
        step();
        check("ack_edge11", int'(vote_ack), 1);
        check("ack_led", int'(led), MAXC);
        check("ack_disarm", int'(armed), 0);
        step();
        check("ack_one_pulse", int'(vote_ack), 0);
        check("winner_2", int'(winner), 2);
        button = '0;
        repeat (98) step();
        check("ack_led_last", int'(led), MAXC);
        step();
        check("ack_led_off", int'(led), 0);

        do_reset();
        arm_booth();
        button = 4'b0010;
        repeat (9) step();
        button = '0;
        repeat (4) step();
        check("short_press_armed", int'(armed), 1);
        if (LOCKOUT) begin
            do_reset();
            button = 4'b0010;
            repeat (12) step();
            button = '0;
            mode = 1'b1; sel = 2'd1;
            step();
            check("unarmed_tally1", int'(led), 0);
            mode = 1'b0;
            step();
        end

        do_reset();
        arm_booth();
        button = 4'b1001;
        repeat (HOLD_CYC + 1) step();
        check("spoil_count", int'(spoiled), 1);
        check("spoil_no_ack", int'(vote_ack), 0);
        button = '0;
        step();
        mode = 1'b1; sel = 2'd0;
        step();
        check("spoil_tally0", int'(led), 0);
        mode = 1'b0;
        step();

        do_reset();
        repeat (MAXC) fast_vote(0);
        mode = 1'b1; sel = 2'd0;
        step();
        check("preload_255", int'(led), MAXC);
        sel = 2'd1;
        step();
        check("sel_follow", int'(led), 0);
        mode = 1'b0;
        step();
        arm_booth();
        button = 4'b0001;
        repeat (HOLD_CYC + 1) step();
        check("sat_vote_ack", int'(vote_ack), 1);
        button = '0;
        repeat (ACK_CYC) step();
        mode = 1'b1; sel = 2'd0;
        step();
        check("saturated", int'(led), MAXC);
        mode = 1'b0;
        step();

        do_reset();
        fast_vote(1); fast_vote(3); fast_vote(1); fast_vote(3); fast_vote(0);
        check("tie_winner", int'(winner), 1);
        check("tie_flag", int'(tie), 1);
        fast_vote(3);
        check("untie_winner", int'(winner), 3);
        check("untie_flag", int'(tie), 0);

        do_reset();
        arm_booth();
        button = 4'b0001;
        repeat (HOLD_CYC + 1) step();
        button = '0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midack_led", int'(led), 0);
        check("midack_armed", int'(armed), 0);
        check("midack_tie", int'(tie), 0);
        check("midack_spoiled", int'(spoiled), 0);
        arm_booth();
        mode = 1'b1;
        step();
        check("abort_armed", int'(armed), 0);
        button = 4'b0100;
        repeat (HOLD_CYC + 2) step();
        button = '0;
        check("abort_no_ack", int'(vote_ack), 0);
        sel = 2'd2;
        step();
        check("abort_tally2", int'(led), 0);
        mode = 1'b0;
        step();

        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < NUM_CAND; i++)
                if ($urandom_range(0, 15) == 0) button[i] = ~button[i];
            arm = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            sel = SEL_W'($urandom_range(0, NUM_CAND - 1));
            reset = ($urandom_range(0, 699) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
